// File: rtl/instr_loader.sv
// Byte-stream instruction memory loader: packs bytes big-endian into 32-bit words and
// writes them while holding the CPU in reset. Optional trailing checksum: INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  n_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [6:0]  word_count
);

    localparam logic [6:0] MaxWords = 7'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
        StCheck,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  target_q, target_d;
    logic [6:0]  count_q, count_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        mem_we_q, mem_we_d;
    logic        done_q, done_d;
    logic [6:0]  n_lim;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        error_q, error_d;
`endif

    assign n_lim = (n_words > MaxWords) ? MaxWords : n_words;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        count_d    = count_q;
        idx_d      = idx_q;
        word_d     = word_q;
        byte_ready = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        error_d    = error_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    target_d = n_lim;
                    count_d  = '0;
                    idx_d    = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d    = '0;
                    error_d  = 1'b0;
`endif
                    state_d  = (n_lim == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    // Shifting in from the right leaves byte 0 in [31:24] after four bytes.
                    word_d = {word_q[23:0], byte_data};
                    idx_d  = idx_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + byte_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                count_d = count_q + 7'd1;
                if (count_d == target_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StCollect;
                end
            end
            StCheck: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                byte_ready = 1'b1;
                if (byte_valid) begin
                    error_d = (byte_data != sum_q);
                    state_d = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Strobes are flopped from the next state so they align exactly with WRITE/DONE.
        mem_we_d = (state_d == StWrite);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            target_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            mem_we_q <= mem_we_d;
            done_q   <= done_d;
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign mem_we     = mem_we_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle);
    assign cpu_hold   = busy;
    assign mem_addr   = {23'b0, count_q, 2'b00};
    assign mem_wdata  = word_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a queue-based model derives the expected word writes
// from the byte stream; a negedge monitor records what the DUT actually wrote.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  n_words = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  word_count;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cnt    = 0;
    int          overlap_err = 0;
    int          hold_err    = 0;
    logic [7:0]  bytes_q[$];
    logic [7:0]  fixed_q[$];

    instr_loader #(.DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_words    (n_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end
            if (done) done_cnt++;
            if (mem_we && byte_ready) overlap_err++;
            if (busy && !cpu_hold) hold_err++;
        end
    end

    task automatic do_start(input int n);
        start   = 1'b1;
        n_words = 7'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input bit toggle, output bit ok);
        int  i = 0;
        int  cyc = 0;
        bit  acc;
        while (i < bytes_q.size() && cyc < 4000) begin
            byte_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            byte_data  = bytes_q[i];
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
        end
        byte_valid = 1'b0;
        ok = (i == bytes_q.size());
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        ok = !busy;
        @(posedge clk);
        #1;
    endtask

    // Model: word i is bytes 4i..4i+3 big-endian at byte address 4i; count capped at 64.
    task automatic load_and_check(input string name, input int n, input bit toggle,
                                  input bit use_fixed, input bit bad_cks);
        int          nw;
        logic [31:0] exp_data[$];
        logic [7:0]  cks;
        bit          exp_err;
        bit          ok;
        nw = (n > 64) ? 64 : n;
        wr_addr.delete();
        wr_data.delete();
        bytes_q.delete();
        exp_data.delete();
        done_cnt = 0;
        hold_err = 0;
        overlap_err = 0;
        cks = '0;
        for (int i = 0; i < nw * 4; i++) begin
            bytes_q.push_back(use_fixed ? fixed_q[i] : 8'($urandom_range(0, 255)));
            cks = cks + bytes_q[i];
        end
        for (int w = 0; w < nw; w++) begin
            exp_data.push_back({bytes_q[4*w], bytes_q[4*w+1], bytes_q[4*w+2], bytes_q[4*w+3]});
        end
        exp_err = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (nw > 0) begin
            bytes_q.push_back(bad_cks ? cks + 8'd1 : cks);
            exp_err = bad_cks;
        end
`endif
        do_start(n);
        tot_cnt++;
        if ({cpu_hold, busy} !== 2'b11)
            $display("FAIL %s hold_on_start: got %b want 11", name, {cpu_hold, busy});
        else pass_cnt++;
        feed(toggle, ok);
        tot_cnt++;
        if (!ok) $display("FAIL %s feed_timeout: got stalled want all bytes", name);
        else pass_cnt++;
        wait_idle(200, ok);
        tot_cnt++;
        if (!ok) $display("FAIL %s done_timeout: got busy want idle", name);
        else pass_cnt++;
        tot_cnt++;
        if (wr_addr.size() !== nw)
            $display("FAIL %s write_count: got %0d want %0d", name, wr_addr.size(), nw);
        else pass_cnt++;
        for (int w = 0; w < nw && w < wr_addr.size(); w++) begin
            tot_cnt++;
            if (wr_addr[w] !== 32'(4 * w) || wr_data[w] !== exp_data[w])
                $display("FAIL %s word%0d: got %h@%h want %h@%h", name, w, wr_data[w],
                         wr_addr[w], exp_data[w], 32'(4 * w));
            else pass_cnt++;
        end
        tot_cnt++;
        if (done_cnt !== 1) $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
        else pass_cnt++;
        tot_cnt++;
        if (word_count !== 7'(nw))
            $display("FAIL %s word_count: got %0d want %0d", name, word_count, nw);
        else pass_cnt++;
        tot_cnt++;
        if (error !== exp_err) $display("FAIL %s error: got %b want %b", name, error, exp_err);
        else pass_cnt++;
        tot_cnt++;
        if (hold_err !== 0 || overlap_err !== 0 || cpu_hold !== 1'b0)
            $display("FAIL %s hold_ready: got herr=%0d ovl=%0d hold=%b want 0 0 0", name,
                     hold_err, overlap_err, cpu_hold);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #12;
        tot_cnt++;
        if ({byte_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata, word_count}
            !== '0)
            $display("FAIL reset_values: got %b%b%b%b%b%b %h %h %0d want all zero", byte_ready,
                     mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata, word_count);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tot_cnt++;
        if ({byte_ready, busy, cpu_hold} !== 3'b000)
            $display("FAIL idle_after_reset: got %b want 000", {byte_ready, busy, cpu_hold});
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [31:0] img[2];
        img[0] = 32'h2008_0005;
        img[1] = 32'h0000_000C;
        fixed_q.delete();
        for (int w = 0; w < 2; w++)
            for (int b = 3; b >= 0; b--) fixed_q.push_back(img[w][8*b +: 8]);
        load_and_check("directed", 2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        load_and_check("overflow", 80, 1'b0, 1'b0, 1'b0);
        tot_cnt++;
        if (wr_addr.size() == 0 || wr_addr[wr_addr.size() - 1] !== 32'h0000_00FC)
            $display("FAIL overflow_last_addr: got %0d writes want last addr 000000fc",
                     wr_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int seen;
        bit ok;
        wr_addr.delete();
        done_cnt = 0;
        do_start(0);
        seen = 0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (done && seen == 0) seen = c;
        end
        tot_cnt++;
        if (seen == 0) $display("FAIL zero_done: got no done want done within 2 cycles");
        else pass_cnt++;
        wait_idle(20, ok);
        tot_cnt++;
        if (wr_addr.size() !== 0 || done_cnt !== 1 || !ok)
            $display("FAIL zero_writes: got %0d writes %0d dones want 0 writes 1 done",
                     wr_addr.size(), done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_toggle();
        load_and_check("toggle", 1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_start(3);
        bytes_q.delete();
        for (int i = 0; i < 6; i++) bytes_q.push_back(8'($urandom_range(1, 255)));
        feed(1'b0, ok);
        tot_cnt++;
        if (!ok || busy !== 1'b1 || word_count !== 7'd1)
            $display("FAIL midreset_pre: got busy=%b wc=%0d want busy=1 wc=1", busy, word_count);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        tot_cnt++;
        if ({byte_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata, word_count}
            !== '0)
            $display("FAIL midreset_values: got hold=%b busy=%b addr=%h data=%h wc=%0d want 0",
                     cpu_hold, busy, mem_addr, mem_wdata, word_count);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_and_check("after_reset", 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_checksum();
        fixed_q.delete();
        for (int i = 1; i <= 4; i++) fixed_q.push_back(8'(i));
        load_and_check("cks_good", 1, 1'b0, 1'b1, 1'b0);
        load_and_check("cks_bad", 1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++)
            load_and_check("random", int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)),
                           1'b0, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_zero();
        test_toggle();
        test_reset_mid();
        test_checksum();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Writer side of the instruction memory: streams a program into the 64-word instruction memory one byte at a time, so the hex image can be replaced at run time instead of only at elaboration. It assembles bytes from a serial-style source (UART receiver or bench) into 32-bit words, drives a write port into the memory, and holds the processor in reset while loading.

## Interface
- `DEPTH`, 64: number of 32-bit words in the instruction memory; the maximum load length.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load; sampled only in IDLE.
- `n_words` in 7: number of words to load; latched on the accepted `start`.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: program byte.
- `byte_ready` out 1: loader accepts a byte this cycle; transfer happens when `byte_valid && byte_ready`.
- `mem_we` out 1: one-cycle write strobe to instruction memory.
- `mem_addr` out 32: byte address of the word being written; bits [1:0] always 0, so word index = `mem_addr[7:2]`.
- `mem_wdata` out 32: assembled instruction word.
- `cpu_hold` out 1: high from the accepted `start` until `done`; gates the processor reset.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a load.
- `error` out 1: checksum mismatch flag (see Configuration).
- `word_count` out 7: words written so far in the current or last load.

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (only with the macro), DONE.
- IDLE: `byte_ready`=0. `start`=1 latches `min(n_words, DEPTH)`, clears `word_count`, byte index, checksum and `error`, then goes to COLLECT. If the latched count is 0, go straight to DONE with no writes.
- COLLECT: `byte_ready`=1. Each accepted byte fills the word big-endian: byte 0 goes to [31:24] and byte 3 to [7:0], matching the `$readmemh` word order. The 4th accepted byte moves the FSM to WRITE.
- WRITE: `byte_ready`=0, `mem_we`=1, `mem_addr`={`word_count`, 2'b00} zero-extended, and `mem_wdata` is the assembled word. `word_count` increments at the end of the cycle. If the new count equals the latched count, go to CHECK (macro) or DONE; otherwise go to COLLECT.
- DONE: `done`=1 for one cycle, then IDLE. `cpu_hold` drops on the same edge `done` falls.
- `start` while `busy` is ignored.
- `byte_valid` in IDLE, WRITE or DONE is not consumed, because `byte_ready` is 0.
- Address arithmetic: `word_count` never exceeds `DEPTH`, so addresses stay within 0..0xFC and there is no wrap-around.

## Timing
- Reset values: `byte_ready`, `mem_we`, `cpu_hold`, `busy`, `done` and `error` are 0. `mem_addr`, `mem_wdata` and `word_count` are 0. State is IDLE.
- `cpu_hold` and `busy` rise on the edge that accepts `start`.
- Per word: at least 4 COLLECT cycles plus 1 WRITE cycle. With `byte_valid` held high, N words take 5N cycles from the first COLLECT cycle to the end of the last WRITE cycle, plus 1 DONE cycle.
- `mem_we` is registered: it is high exactly during the WRITE state, and the memory captures the word on the following edge.
- Reset asserted mid-load: all outputs go to their reset values immediately (asynchronously) and any partial word is discarded. Words already written stay in memory.
- `start` and the last WRITE in the same cycle: `start` is ignored.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - After the last WRITE the FSM enters CHECK with `byte_ready`=1 and accepts one extra byte.
  - `error` is set if that byte differs from the 8-bit modulo-256 sum of all data bytes. `error` is sticky until the next accepted `start`.
  - DONE follows in either case.
- Macro undefined:
  - No CHECK state, and DONE follows the last WRITE directly.
  - `error` is tied to 0.

## Test plan
- Reset, then `start` with `n_words`=2 and bytes 20 08 00 05 / 00 00 00 0C → two `mem_we` pulses: addr 0x00 data 0x20080005, then addr 0x04 data 0x0000000C. `done` pulses once and `cpu_hold` is high throughout.
- `n_words`=80 with continuous bytes → exactly 64 writes, last addr 0xFC, `word_count`=64.
- `n_words`=0 → no `mem_we`, and `done` pulses 2 cycles after `start`.
- `byte_valid` toggled every other cycle with `n_words`=1 → a single correct word, `mem_we` exactly once, and `byte_ready` low during WRITE.
- `rst_n` dropped after 6 bytes of a 3-word load → outputs zero immediately; a new load then starts cleanly at addr 0x00.
- With the macro, bytes 01 02 03 04 + checksum 0x0A → `error`=0; checksum 0x0B → `error`=1 with `done` still pulsing.
